fp32_adder: RTL and testbench

//  IEEE-754 single-precision adder: z = a + b. Operands arrive over two stb/ack

---
 rtl/fp32_adder_if.sv | 22 ++
 rtl/fp32_adder.sv | 180 ++++++++++++++++++
 tb/tb_fp32_adder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_adder_if.sv
// Operand and result channels of the binary32 adder.
// The adder is the slave; whoever feeds operands and takes results is the master.
interface fp32_adder_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp32_adder.sv
// Multi-cycle IEEE-754 binary32 adder, round-to-nearest-even, one operation in flight.
// Operands arrive on two stb/ack channels; the sum leaves as a one-cycle strobe.
module fp32_adder (
  input  logic         clk,
  input  logic         rst,
  fp32_adder_if.slave  bus
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
    NORM_0, NORM_1, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] EMIN = -10'sd126;
  localparam logic signed [9:0] EMAX = 10'sd127;
  localparam logic [31:0]       QNAN = 32'h7FC0_0000;

  state_t state, state_next;

  logic [31:0]       a, b;
  logic              a_s, b_s, z_s;
  logic signed [9:0] a_e, b_e, z_e;
  // Significand at bit 26 down to bit 3, then guard, round, sticky.
  logic [26:0]       a_m, b_m;
  logic [27:0]       sum;
  logic [23:0]       z_m;
  logic              guard, rnd, sticky;

  logic        a_ack, b_ack, z_stb;
  logic [31:0] z, result;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_zero = (a[30:0] == 31'd0);
  assign b_zero = (b[30:0] == 31'd0);

  assign bus.input_a_ack  = a_ack;
  assign bus.input_b_ack  = b_ack;
  assign bus.output_z     = z;
  assign bus.output_z_stb = z_stb;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    result     = 32'd0;
    case (state)
      GET_A:   if (a_ack && bus.input_a_stb) state_next = GET_B;
      GET_B:   if (b_ack && bus.input_b_stb) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: begin
        state_next = PUT_Z;
        if (a_nan || b_nan)                       result = QNAN;
        else if (a_inf && b_inf && a[31] != b[31]) result = QNAN;
        else if (a_inf)                           result = a;
        else if (b_inf)                           result = b;
        else if (a_zero && b_zero)                result = {a[31] & b[31], 31'd0};
        else if (a_zero)                          result = b;
        else if (b_zero)                          result = a;
        else                                      state_next = ALIGN;
      end
      ALIGN:   if (a_e == b_e) state_next = ADD_0;
      ADD_0:   state_next = ADD_1;
      ADD_1:   state_next = NORM_0;
      NORM_0:  if (z_m[23] || z_e <= EMIN) state_next = NORM_1;
      NORM_1:  if (z_e >= EMIN) state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK: begin
        state_next = PUT_Z;
        if (z_e > EMAX)                      result = {z_s, 8'hFF, 23'd0};
        else if (z_e == EMIN && !z_m[23])    result = {z_s, 8'h00, z_m[22:0]};
        else                                 result = {z_s, 8'(z_e + 10'sd127), z_m[22:0]};
      end
      PUT_Z:   state_next = GET_A;
      default: state_next = GET_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= GET_A;
    else     state <= state_next;
  end

  // Acks and strobe are decoded from the next state, so they are registered and
  // never depend combinationally on an incoming stb.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      z_stb <= 1'b0;
      z     <= 32'd0;
    end else begin
      a_ack <= (state_next == GET_A);
      b_ack <= (state_next == GET_B);
      z_stb <= (state_next == PUT_Z);
      if (state_next == PUT_Z) z <= result;
    end
  end

  // NOTE: the datapath carries no reset; every field is written before the state that reads it.
  always_ff @(posedge clk) begin
    case (state)
      GET_A: if (a_ack && bus.input_a_stb) a <= bus.input_a;
      GET_B: if (b_ack && bus.input_b_stb) b <= bus.input_b;
      UNPACK: begin
        a_s <= a[31];
        b_s <= b[31];
        a_m <= {a[30:23] != 8'd0, a[22:0], 3'b000};
        b_m <= {b[30:23] != 8'd0, b[22:0], 3'b000};
        a_e <= (a[30:23] == 8'd0) ? EMIN : $signed({2'b00, a[30:23]}) - 10'sd127;
        b_e <= (b[30:23] == 8'd0) ? EMIN : $signed({2'b00, b[30:23]}) - 10'sd127;
      end
      ALIGN: begin
        if (a_e > b_e) begin
          b_e <= b_e + 10'sd1;
          b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
        end else if (a_e < b_e) begin
          a_e <= a_e + 10'sd1;
          a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
        end
      end
      ADD_0: begin
        z_e <= a_e;
        if (a_s == b_s) begin
          sum <= {1'b0, a_m} + {1'b0, b_m};
          z_s <= a_s;
        end else if (a_m >= b_m) begin
          sum <= {1'b0, a_m - b_m};
          z_s <= (a_m == b_m) ? 1'b0 : a_s;
        end else begin
          sum <= {1'b0, b_m - a_m};
          z_s <= b_s;
        end
      end
      ADD_1: begin
        if (sum[27]) begin
          z_m    <= sum[27:4];
          guard  <= sum[3];
          rnd    <= sum[2];
          sticky <= sum[1] | sum[0];
          z_e    <= z_e + 10'sd1;
        end else begin
          z_m    <= sum[26:3];
          guard  <= sum[2];
          rnd    <= sum[1];
          sticky <= sum[0];
        end
      end
      NORM_0: begin
        if (!z_m[23] && z_e > EMIN) begin
          z_e   <= z_e - 10'sd1;
          z_m   <= {z_m[22:0], guard};
          guard <= rnd;
          rnd   <= 1'b0;
        end
      end
      NORM_1: begin
        if (z_e < EMIN) begin
          z_e    <= z_e + 10'sd1;
          z_m    <= {1'b0, z_m[23:1]};
          guard  <= z_m[0];
          rnd    <= guard;
          sticky <= sticky | rnd;
        end
      end
      ROUND: begin
        if (guard && (rnd || sticky || z_m[0])) begin
          z_m <= z_m + 24'd1;
          if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp32_adder.sv
// Self-checking bench for fp32_adder: directed corner cases, reset abort, out-of-order
// operands, and random operands against an exact wide-integer reference model.
module tb_fp32_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fp32_adder_if bus ();

  fp32_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int NDIR = 14;
  logic [31:0] dir_a [NDIR] = '{32'h3F800000, 32'h3FC00000, 32'h80000000, 32'h7F800000,
                                32'h7FC00000, 32'h7F7FFFFF, 32'h00000001, 32'h3F800000,
                                32'h3F800001, 32'h7F7FFFFF, 32'h00000000, 32'hFF800000,
                                32'h00000000, 32'h00800000};
  logic [31:0] dir_b [NDIR] = '{32'h40000000, 32'hBFC00000, 32'h80000000, 32'hFF800000,
                                32'h3F800000, 32'h7F7FFFFF, 32'h00000001, 32'h33800000,
                                32'h33800000, 32'h00000001, 32'hBF800000, 32'h3F800000,
                                32'h80000000, 32'h80000001};
  logic [31:0] dir_z [NDIR] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h7FC00000,
                                32'h7FC00000, 32'h7F800000, 32'h00000002, 32'h3F800000,
                                32'h3F800002, 32'h7F7FFFFF, 32'hBF800000, 32'hFF800000,
                                32'h00000000, 32'h007FFFFF};
  bit          dir_sp [NDIR] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Magnitude of a finite operand in units of 2^-149.
  function automatic logic [299:0] mag(input logic [31:0] x);
    logic [299:0] m;
    m = 300'({x[30:23] != 8'd0, x[22:0]});
    if (x[30:23] != 8'd0) m = m << (int'(x[30:23]) - 1);
    return m;
  endfunction

  // Exact sum, then a single round-to-nearest-even to binary32.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, s, kept, rem, half;
    logic sign;
    int p, sh, e;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = a[30:23] == 8'hFF && a[22:0] != 23'd0;
    b_nan  = b[30:23] == 8'hFF && b[22:0] != 23'd0;
    a_inf  = a[30:23] == 8'hFF && a[22:0] == 23'd0;
    b_inf  = b[30:23] == 8'hFF && b[22:0] == 23'd0;
    a_zero = a[30:0] == 31'd0;
    b_zero = b[30:0] == 31'd0;
    if (a_nan || b_nan) return 32'h7FC00000;
    if (a_inf && b_inf && a[31] != b[31]) return 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    ma = mag(a);
    mb = mag(b);
    if (a[31] == b[31]) begin s = ma + mb; sign = a[31]; end
    else if (ma >= mb)  begin s = ma - mb; sign = a[31]; end
    else                begin s = mb - ma; sign = b[31]; end
    if (s == '0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    sh = (p > 23) ? p - 23 : 0;
    kept = s >> sh;
    if (sh > 0) begin
      rem  = s & ((300'(1) << sh) - 300'(1));
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 300'(1);
    end
    if (kept[24]) begin kept = kept >> 1; sh++; end
    e = kept[23] ? sh + 1 : 0;
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    return {sign, 8'(e), kept[22:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input bit is_b, input logic [31:0] v);
    int n;
    logic ack;
    if (is_b) begin bus.input_b = v; bus.input_b_stb = 1'b1; end
    else      begin bus.input_a = v; bus.input_a_stb = 1'b1; end
    n = 0;
    ack = is_b ? bus.input_b_ack : bus.input_a_ack;
    while (ack !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      ack = is_b ? bus.input_b_ack : bus.input_a_ack;
    end
    check(is_b ? "b_ack_wait" : "a_ack_wait", {31'd0, ack}, 32'd1);
    @(negedge clk);
    if (is_b) bus.input_b_stb = 1'b0;
    else      bus.input_a_stb = 1'b0;
  endtask

  // lat counts rising edges after the B handshake edge until the strobe is seen.
  task automatic get_z(output logic [31:0] z, output int lat);
    lat = 0;
    while (bus.output_z_stb !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("z_stb_wait", {31'd0, bus.output_z_stb}, 32'd1);
    z = bus.output_z;
    @(negedge clk);
    check("z_stb_pulse", {31'd0, bus.output_z_stb}, 32'd0);
  endtask

  task automatic add_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] z, output int lat);
    send(1'b0, a);
    send(1'b1, b);
    get_z(z, lat);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] z;
    int lat, seen;
    bus.input_a = '0; bus.input_a_stb = 1'b0;
    bus.input_b = '0; bus.input_b_stb = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, bus.input_b_ack}, 32'd0);
    check("rst_z", bus.output_z, 32'd0);
    check("rst_z_stb", {31'd0, bus.output_z_stb}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("a_ack_after_rst", {31'd0, bus.input_a_ack}, 32'd1);

    for (int i = 0; i < NDIR; i++) begin
      add_op(dir_a[i], dir_b[i], z, lat);
      check($sformatf("dir%0d %08h+%08h", i, dir_a[i], dir_b[i]), z, dir_z[i]);
      if (dir_sp[i]) check($sformatf("dir%0d special_lat=%0d", i, lat), {31'd0, lat <= 5}, 32'd1);
      else           check($sformatf("dir%0d lat=%0d", i, lat), {31'd0, lat < 320}, 32'd1);
    end

    // B offered before A: it must wait until A has been taken.
    bus.input_b = 32'h40000000;
    bus.input_b_stb = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.input_b_ack === 1'b1 || bus.output_z_stb === 1'b1) seen++;
    end
    check("b_before_a_ignored", seen, 32'd0);
    send(1'b0, 32'h3F800000);
    send(1'b1, 32'h40000000);
    get_z(z, lat);
    check("out_of_order_sum", z, 32'h40400000);

    // Abandon a long alignment with reset.
    send(1'b0, 32'h3F800000);
    send(1'b1, 32'h00000001);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.output_z_stb === 1'b1) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (bus.output_z_stb === 1'b1) seen++;
    check("mid_rst_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
    @(negedge clk);
    if (bus.output_z_stb === 1'b1) seen++;
    rst = 1'b0;
    @(negedge clk);
    check("a_ack_after_mid_rst", {31'd0, bus.input_a_ack}, 32'd1);
    repeat (300) begin
      @(negedge clk);
      if (bus.output_z_stb === 1'b1) seen++;
    end
    check("no_stb_after_abort", seen, 32'd0);
    add_op(32'h3F800000, 32'h40000000, z, lat);
    check("sum_after_abort", z, 32'h40400000);

    for (int i = 0; i < 160; i++) begin
      logic [31:0] ra, rb;
      case (i % 4)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin
          ra = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
        end
        2: begin
          ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
          rb = {~ra[31], ra[30:0] ^ {23'd0, 8'($urandom)}};
        end
        default: begin
          ra = {1'($urandom), 8'd0, 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
        end
      endcase
      add_op(ra, rb, z, lat);
      check($sformatf("rand%0d %08h+%08h", i, ra, rb), z, ref_add(ra, rb));
      check($sformatf("rand%0d lat=%0d", i, lat), {31'd0, lat < 320}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
